// File: rtl/mc_controller_if.sv
// mc_controller_if: control/strobe bundle between the multicycle controller
// (master) and the datapath/memory side (slave).
interface mc_controller_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned ALUW = 4;
  localparam int unsigned STW  = 4;
  localparam int unsigned CNTW = 16;

  logic [WIDTH-1:0] instr;
  logic             zero;
  logic             memready;

  logic             memtoreg;
  logic             alusrc;
  logic             regdst;
  logic             regwrite;
  logic             jump;
  logic             pcsrc;
  logic [ALUW-1:0]  alucontrol;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             pcwrite;
  logic             illegal;
  logic [STW-1:0]   state;
  logic [CNTW-1:0]  retired;

  modport master (
    input  instr, zero, memready,
    output memtoreg, alusrc, regdst, regwrite, jump, pcsrc, alucontrol,
           memread, memwrite, irwrite, pcwrite, illegal, state, retired
  );

  modport slave (
    output instr, zero, memready,
    input  memtoreg, alusrc, regdst, regwrite, jump, pcsrc, alucontrol,
           memread, memwrite, irwrite, pcwrite, illegal, state, retired
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the 16-bit datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on memready.
// Optional feature: define MC_CTRL_PERF_EN to build the retired-instruction
// counter; otherwise retired is tied to zero.
module mc_controller #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);
  localparam int unsigned OPW  = 4;
  localparam int unsigned ALUW = 4;
  localparam int unsigned CNTW = 16;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 4'h0;
  localparam logic [OPW-1:0] OP_ADDI = 4'h1;
  localparam logic [OPW-1:0] OP_LW   = 4'h2;
  localparam logic [OPW-1:0] OP_SW   = 4'h3;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h4;
  localparam logic [OPW-1:0] OP_J    = 4'h5;

  localparam logic [ALUW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUW-1:0] ALU_SLT = 4'b0111;

  state_t          state_q;
  logic [OPW-1:0]  opcode;
  logic [2:0]      funct;
  logic [ALUW-1:0] funct_alu;
  logic            funct_legal;
  logic            instr_legal;
  logic            retire;
  logic            unused_instr_bits;

  assign opcode            = bus.instr[WIDTH-1 -: OPW];
  assign funct             = bus.instr[2:0];
  assign unused_instr_bits = ^bus.instr[WIDTH-OPW-1:3];

  // R-type funct to ALU operation; unknown funct codes are flagged illegal
  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      3'b000:  funct_alu = ALU_ADD;
      3'b001:  funct_alu = ALU_SUB;
      3'b010:  funct_alu = ALU_AND;
      3'b011:  funct_alu = ALU_OR;
      3'b100:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
    instr_legal = (opcode <= OP_J) && ((opcode != OP_R) || funct_legal);
  end

  // State register with next-state sequencing; memready stalls the memory steps
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:   if (bus.memready) state_q <= DECODE;
        DECODE: begin
          if (!instr_legal) begin
            state_q <= FETCH;
          end else begin
            case (opcode)
              OP_R:         state_q <= EXEC;
              OP_ADDI:      state_q <= ADDIEX;
              OP_LW, OP_SW: state_q <= MEMADR;
              OP_BEQ:       state_q <= BRANCH;
              OP_J:         state_q <= JUMP;
              default:      state_q <= FETCH;
            endcase
          end
        end
        MEMADR: begin
          if (opcode == OP_LW)      state_q <= MEMRD;
          else if (opcode == OP_SW) state_q <= MEMWR;
          else                      state_q <= FETCH;
        end
        MEMRD:   if (bus.memready) state_q <= MEMWB;
        MEMWB:   state_q <= FETCH;
        MEMWR:   if (bus.memready) state_q <= FETCH;
        EXEC:    state_q <= ALUWB;
        ALUWB:   state_q <= FETCH;
        BRANCH:  state_q <= FETCH;
        ADDIEX:  state_q <= ADDIWB;
        ADDIWB:  state_q <= FETCH;
        JUMP:    state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Moore output decode; reset forces every strobe low so an aborted access writes nothing
  always_comb begin
    bus.memtoreg   = 1'b0;
    bus.alusrc     = 1'b0;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.jump       = 1'b0;
    bus.pcsrc      = 1'b0;
    bus.alucontrol = ALU_ADD;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.illegal    = 1'b0;
    retire         = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.memread = 1'b1;
          bus.irwrite = bus.memready;
          bus.pcwrite = bus.memready;
        end
        DECODE:  bus.illegal = !instr_legal;
        MEMADR:  bus.alusrc = 1'b1;
        MEMRD:   bus.memread = 1'b1;
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
          retire       = 1'b1;
        end
        MEMWR: begin
          bus.memwrite = 1'b1;
          retire       = bus.memready;
        end
        EXEC:    bus.alucontrol = funct_alu;
        ALUWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
          retire       = 1'b1;
        end
        BRANCH: begin
          bus.alucontrol = ALU_SUB;
          bus.pcsrc      = bus.zero;
          bus.pcwrite    = bus.zero;
          retire         = 1'b1;
        end
        ADDIEX:  bus.alusrc = 1'b1;
        ADDIWB: begin
          bus.regwrite = 1'b1;
          retire       = 1'b1;
        end
        JUMP: begin
          bus.jump    = 1'b1;
          bus.pcwrite = 1'b1;
          retire      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = reset ? FETCH : state_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNTW-1:0] retired_q;

  // Retired-instruction counter, bumped on the last cycle of each legal instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNTW'(1);
    end
  end

  assign bus.retired = reset ? '0 : retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign bus.retired   = CNTW'(0);
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed per-cycle vectors with a scoreboard queue; the
// driver pushes the hand-computed expected outputs, the monitor pops/compares.
module tb_mc_controller;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  mc_controller_if #(.WIDTH(16)) bus ();

  mc_controller #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected vector: {state, alucontrol, memtoreg, alusrc, regdst, regwrite,
  //                   jump, pcsrc, memread, memwrite, irwrite, pcwrite, illegal}
  localparam logic [18:0] E_RST   = {4'd0,  4'b0010, 11'b00000000000};
  localparam logic [18:0] E_FWAIT = {4'd0,  4'b0010, 11'b00000010000};
  localparam logic [18:0] E_FRDY  = {4'd0,  4'b0010, 11'b00000010110};
  localparam logic [18:0] E_DEC   = {4'd1,  4'b0010, 11'b00000000000};
  localparam logic [18:0] E_DILL  = {4'd1,  4'b0010, 11'b00000000001};
  localparam logic [18:0] E_MADR  = {4'd2,  4'b0010, 11'b01000000000};
  localparam logic [18:0] E_MRD   = {4'd3,  4'b0010, 11'b00000010000};
  localparam logic [18:0] E_MWB   = {4'd4,  4'b0010, 11'b10010000000};
  localparam logic [18:0] E_MWR   = {4'd5,  4'b0010, 11'b00000001000};
  localparam logic [18:0] E_EXADD = {4'd6,  4'b0010, 11'b00000000000};
  localparam logic [18:0] E_EXSUB = {4'd6,  4'b0110, 11'b00000000000};
  localparam logic [18:0] E_EXAND = {4'd6,  4'b0000, 11'b00000000000};
  localparam logic [18:0] E_EXOR  = {4'd6,  4'b0001, 11'b00000000000};
  localparam logic [18:0] E_EXSLT = {4'd6,  4'b0111, 11'b00000000000};
  localparam logic [18:0] E_ALUWB = {4'd7,  4'b0010, 11'b00110000000};
  localparam logic [18:0] E_BR1   = {4'd8,  4'b0110, 11'b00000100010};
  localparam logic [18:0] E_BR0   = {4'd8,  4'b0110, 11'b00000000000};
  localparam logic [18:0] E_AEX   = {4'd9,  4'b0010, 11'b01000000000};
  localparam logic [18:0] E_AWB   = {4'd10, 4'b0010, 11'b00010000000};
  localparam logic [18:0] E_JMP   = {4'd11, 4'b0010, 11'b00001000010};

  typedef struct {
    logic [18:0] vec;
    logic [15:0] ret;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [15:0] ret_exp  = 16'd0;

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic cyc(input logic [15:0] i, input logic z, input logic m,
                     input logic r, input logic [18:0] e, input bit fin,
                     input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    bus.instr    = i;
    bus.zero     = z;
    bus.memready = m;
    reset        = r;
    if (r) ret_exp = 16'd0;
    x.vec  = e;
    x.ret  = ret_exp;
    x.name = nm;
    sb_q.push_back(x);
`ifdef MC_CTRL_PERF_EN
    if (fin) ret_exp = ret_exp + 16'd1;
`endif
  endtask

  // Monitor: compare outputs mid-cycle whenever an expectation is pending
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        x;
      logic [18:0] act;
      x   = sb_q.pop_front();
      act = {bus.state, bus.alucontrol, bus.memtoreg, bus.alusrc, bus.regdst,
             bus.regwrite, bus.jump, bus.pcsrc, bus.memread, bus.memwrite,
             bus.irwrite, bus.pcwrite, bus.illegal};
      chk_cnt = chk_cnt + 1;
      if (act !== x.vec || bus.retired !== x.ret)
        $display("FAIL %s: got vec=%05h retired=%04h, want vec=%05h retired=%04h",
                 x.name, act, bus.retired, x.vec, x.ret);
      else
        pass_cnt = pass_cnt + 1;
    end
  end

  initial begin
    bus.instr    = 16'h0000;
    bus.zero     = 1'b0;
    bus.memready = 1'b1;

    cyc(16'h0000, 0, 1, 1, E_RST,   0, "reset0");
    cyc(16'h0000, 0, 1, 1, E_RST,   0, "reset1");

    // R-type add
    cyc(16'h0000, 0, 1, 0, E_FRDY,  0, "add_fetch");
    cyc(16'h0000, 0, 1, 0, E_DEC,   0, "add_decode");
    cyc(16'h0000, 0, 1, 0, E_EXADD, 0, "add_exec");
    cyc(16'h0000, 0, 1, 0, E_ALUWB, 1, "add_aluwb");

    // LW with three memready=0 cycles in MEMRD
    cyc(16'h2000, 0, 1, 0, E_FRDY,  0, "lw_fetch");
    cyc(16'h2000, 0, 1, 0, E_DEC,   0, "lw_decode");
    cyc(16'h2000, 0, 1, 0, E_MADR,  0, "lw_memadr");
    cyc(16'h2000, 0, 0, 0, E_MRD,   0, "lw_memrd_w0");
    cyc(16'h2000, 0, 0, 0, E_MRD,   0, "lw_memrd_w1");
    cyc(16'h2000, 0, 0, 0, E_MRD,   0, "lw_memrd_w2");
    cyc(16'h2000, 0, 1, 0, E_MRD,   0, "lw_memrd_rdy");
    cyc(16'h2000, 0, 1, 0, E_MWB,   1, "lw_memwb");

    // BEQ taken then not taken
    cyc(16'h4000, 1, 1, 0, E_FRDY,  0, "beq1_fetch");
    cyc(16'h4000, 1, 1, 0, E_DEC,   0, "beq1_decode");
    cyc(16'h4000, 1, 1, 0, E_BR1,   1, "beq1_branch");
    cyc(16'h4000, 0, 1, 0, E_FRDY,  0, "beq0_fetch");
    cyc(16'h4000, 0, 1, 0, E_DEC,   0, "beq0_decode");
    cyc(16'h4000, 0, 1, 0, E_BR0,   1, "beq0_branch");

    // Illegal opcode, then illegal R-type funct
    cyc(16'hF000, 0, 1, 0, E_FRDY,  0, "ill_op_fetch");
    cyc(16'hF000, 0, 1, 0, E_DILL,  0, "ill_op_decode");
    cyc(16'h0007, 0, 1, 0, E_FRDY,  0, "ill_fn_fetch");
    cyc(16'h0007, 0, 1, 0, E_DILL,  0, "ill_fn_decode");

    // ADDI with two fetch stalls
    cyc(16'h1000, 0, 0, 0, E_FWAIT, 0, "addi_fwait0");
    cyc(16'h1000, 0, 0, 0, E_FWAIT, 0, "addi_fwait1");
    cyc(16'h1000, 0, 1, 0, E_FRDY,  0, "addi_fetch");
    cyc(16'h1000, 0, 1, 0, E_DEC,   0, "addi_decode");
    cyc(16'h1000, 0, 1, 0, E_AEX,   0, "addi_ex");
    cyc(16'h1000, 0, 1, 0, E_AWB,   1, "addi_wb");

    // Remaining R-type ALU codes
    cyc(16'h0001, 0, 1, 0, E_FRDY,  0, "sub_fetch");
    cyc(16'h0001, 0, 1, 0, E_DEC,   0, "sub_decode");
    cyc(16'h0001, 0, 1, 0, E_EXSUB, 0, "sub_exec");
    cyc(16'h0001, 0, 1, 0, E_ALUWB, 1, "sub_aluwb");
    cyc(16'h0002, 0, 1, 0, E_FRDY,  0, "and_fetch");
    cyc(16'h0002, 0, 1, 0, E_DEC,   0, "and_decode");
    cyc(16'h0002, 0, 1, 0, E_EXAND, 0, "and_exec");
    cyc(16'h0002, 0, 1, 0, E_ALUWB, 1, "and_aluwb");
    cyc(16'h0003, 0, 1, 0, E_FRDY,  0, "or_fetch");
    cyc(16'h0003, 0, 1, 0, E_DEC,   0, "or_decode");
    cyc(16'h0003, 0, 1, 0, E_EXOR,  0, "or_exec");
    cyc(16'h0003, 0, 1, 0, E_ALUWB, 1, "or_aluwb");
    cyc(16'h0004, 0, 1, 0, E_FRDY,  0, "slt_fetch");
    cyc(16'h0004, 0, 1, 0, E_DEC,   0, "slt_decode");
    cyc(16'h0004, 0, 1, 0, E_EXSLT, 0, "slt_exec");
    cyc(16'h0004, 0, 1, 0, E_ALUWB, 1, "slt_aluwb");

    // Jump
    cyc(16'h5000, 0, 1, 0, E_FRDY,  0, "j_fetch");
    cyc(16'h5000, 0, 1, 0, E_DEC,   0, "j_decode");
    cyc(16'h5000, 0, 1, 0, E_JMP,   1, "j_jump");

    // SW completing normally
    cyc(16'h3000, 0, 1, 0, E_FRDY,  0, "sw_fetch");
    cyc(16'h3000, 0, 1, 0, E_DEC,   0, "sw_decode");
    cyc(16'h3000, 0, 1, 0, E_MADR,  0, "sw_memadr");
    cyc(16'h3000, 0, 1, 0, E_MWR,   1, "sw_memwr");

    // SW aborted by reset while stalled in MEMWR
    cyc(16'h3000, 0, 1, 0, E_FRDY,  0, "swr_fetch");
    cyc(16'h3000, 0, 1, 0, E_DEC,   0, "swr_decode");
    cyc(16'h3000, 0, 1, 0, E_MADR,  0, "swr_memadr");
    cyc(16'h3000, 0, 0, 0, E_MWR,   0, "swr_memwr_wait");
    cyc(16'h3000, 0, 0, 1, E_RST,   0, "swr_reset");
    cyc(16'h3000, 0, 0, 0, E_FWAIT, 0, "swr_after_reset");
    cyc(16'h5000, 0, 1, 0, E_FRDY,  0, "j2_fetch");
    cyc(16'h5000, 0, 1, 0, E_DEC,   0, "j2_decode");
    cyc(16'h5000, 0, 1, 0, E_JMP,   1, "j2_jump");
    cyc(16'h0000, 0, 0, 0, E_FWAIT, 0, "final_fetch");

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk_cnt = chk_cnt + 1;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
